datapath_seq: RTL and testbench
===============================

DATAPATH_SEQ -- requirements
Module: datapath_seq

Interface
REQ-001 Parameter WIDTH, default 16: datapath and register width in bits, minimum 8.
REQ-002 Parameter NREGS, default 8: register-file depth, power of two, minimum 2.
REQ-003 Parameter IDXW, default $clog2(NREGS): register index width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 start  in  1  request to execute one operation; sampled only in IDLE.
REQ-007 rsel_a  in  IDXW  source register index for operand A.
REQ-008 rsel_b  in  IDXW  source register index for operand B.
REQ-009 writenum  in  IDXW  destination register index.
REQ-010 shift  in  2  B-operand shifter mode.
REQ-011 ALUop  in  2  ALU operation select.
REQ-012 asel  in  1  1 = force ALU A input to zero.
REQ-013 bsel  in  1  1 = ALU B input is immediate from datapath_in[4:0].
REQ-014 vsel  in  1  1 = write datapath_in directly to writenum, no ALU.
REQ-015 datapath_in  in  WIDTH  immediate / load value.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 done  out  1  one-cycle pulse in WB state.
REQ-018 status  out  3  {V, N, Z} flags of last ALU result.
REQ-019 datapath_out  out  WIDTH  contents of result register C.

Function
REQ-020 FSM states SHALL be IDLE, RDA, RDB, EXEC, WB.
REQ-021 IDLE with start=1 SHALL latch all command inputs, including datapath_in, and go to RDA if vsel=0, or to WB if vsel=1.
REQ-022 Transitions SHALL be RDA->RDB->EXEC->WB->IDLE, unconditional, one cycle each.
REQ-023 start while busy=1 SHALL be ignored; commands are not queued.
REQ-024 RDA SHALL load register A from reg[rsel_a]; RDB SHALL load register B from reg[rsel_b].
REQ-025 Shifter on B: 00 pass; 01 left 1, LSB 0; 10 logical right 1; 11 arithmetic right 1 (MSB replicated).
REQ-026 ALU inputs: Ain = asel ? 0 : A; Bin = bsel ? zero-extend(datapath_in[4:0]) : shifted B.
REQ-027 ALUop: 00 Ain+Bin; 01 Ain-Bin; 10 Ain&Bin; 11 ~Bin; results truncated to WIDTH, modulo 2^WIDTH.
REQ-028 EXEC SHALL load C with the ALU result and update status.
REQ-029 Z SHALL be 1 iff the result is 0; N SHALL equal result[WIDTH-1].
REQ-030 V SHALL be signed two's-complement overflow for 00/01 and 0 for 10/11.
REQ-031 WB SHALL write the latched datapath_in (vsel=1) or C (vsel=0) into reg[writenum] on the WB clock edge, and assert done=1 for that cycle only.
REQ-032 vsel=1 operations SHALL NOT modify A, B, C or status.
REQ-033 Latency: vsel=0 SHALL give done 4 cycles after the start-accept edge; vsel=1 SHALL give done 1 cycle after.
REQ-034 start may be high in the WB cycle; it is ignored, and a new command is accepted no earlier than the first IDLE cycle.
REQ-035 rsel_a, rsel_b and writenum may be equal; reads SHALL see values written by prior completed operations.

Reset
REQ-036 rst_n=0 SHALL immediately force the FSM to IDLE and clear all registers, A, B, C and status to 0.
REQ-037 During reset, busy, done, status and datapath_out SHALL be 0.
REQ-038 Reset mid-operation SHALL abort the operation with no register write.

Verification
REQ-039 Load: vsel=1, datapath_in=0x0007, writenum=3 -> done 1 cycle later, reg3=0x0007, status unchanged.
REQ-040 Add with shift: R0=7, R1=2; rsel_a=0, rsel_b=1, shift=01, ALUop=00 -> datapath_out=0x000B, status=000, done at cycle 4.
REQ-041 Overflow: R0=0x7FFF, R1=1, ALUop=00 -> C=0x8000, status V=1, N=1, Z=0.
REQ-042 Zero result: R0=5, R1=5, ALUop=01 -> C=0x0000, Z=1; asel=1, ALUop=11, B=0xFFFF -> C=0x0000, Z=1.
REQ-043 Protocol: start held high through an operation -> exactly one done pulse per accepted command; start during busy ignored.
REQ-044 Reset: rst_n low during EXEC -> busy=0 at once, destination register stays 0, next start operates normally; repeat with NREGS=16, WIDTH=32.

Source files
------------

// File: rtl/datapath_seq.sv
// Sequenced register-file datapath: a five-state FSM reads two operands, runs the
// B-shifter and ALU, and writes the result (or a latched immediate) back to a register.
module datapath_seq #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int IDXW  = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [IDXW-1:0]  rsel_a,
    input  logic [IDXW-1:0]  rsel_b,
    input  logic [IDXW-1:0]  writenum,
    input  logic [1:0]       shift,
    input  logic [1:0]       ALUop,
    input  logic             asel,
    input  logic             bsel,
    input  logic             vsel,
    input  logic [WIDTH-1:0] datapath_in,
    output logic             busy,
    output logic             done,
    output logic [2:0]       status,
    output logic [WIDTH-1:0] datapath_out
);

    typedef enum logic [2:0] {
        IDLE,
        RDA,
        RDB,
        EXEC,
        WB
    } state_t;

    state_t state_q, state_d;

    // Command captured at accept; the live inputs are ignored until the next IDLE.
    logic [IDXW-1:0]  rsel_a_q, rsel_a_d;
    logic [IDXW-1:0]  rsel_b_q, rsel_b_d;
    logic [IDXW-1:0]  writenum_q, writenum_d;
    logic [1:0]       shift_q, shift_d;
    logic [1:0]       aluop_q, aluop_d;
    logic             asel_q, asel_d;
    logic             bsel_q, bsel_d;
    logic             vsel_q, vsel_d;
    logic [WIDTH-1:0] din_q, din_d;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [2:0]       status_q, status_d;
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];

    logic [WIDTH-1:0] b_shift;
    logic [WIDTH-1:0] ain;
    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] alu_res;
    logic             alu_v;

    always_comb begin
        case (shift_q)
            2'b00:   b_shift = b_q;
            2'b01:   b_shift = {b_q[WIDTH-2:0], 1'b0};
            2'b10:   b_shift = {1'b0, b_q[WIDTH-1:1]};
            default: b_shift = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
        endcase

        ain = asel_q ? '0 : a_q;
        bin = bsel_q ? {{(WIDTH-5){1'b0}}, din_q[4:0]} : b_shift;

        // Overflow: operands (with B's sign flipped for subtract) agree in sign but the result does not.
        alu_v = 1'b0;
        case (aluop_q)
            2'b00: begin
                alu_res = ain + bin;
                alu_v   = (ain[WIDTH-1] == bin[WIDTH-1]) && (alu_res[WIDTH-1] != ain[WIDTH-1]);
            end
            2'b01: begin
                alu_res = ain - bin;
                alu_v   = (ain[WIDTH-1] != bin[WIDTH-1]) && (alu_res[WIDTH-1] != ain[WIDTH-1]);
            end
            2'b10:   alu_res = ain & bin;
            default: alu_res = ~bin;
        endcase
    end

    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case leaves a signal unassigned (no latch).
        state_d    = state_q;
        rsel_a_d   = rsel_a_q;
        rsel_b_d   = rsel_b_q;
        writenum_d = writenum_q;
        shift_d    = shift_q;
        aluop_d    = aluop_q;
        asel_d     = asel_q;
        bsel_d     = bsel_q;
        vsel_d     = vsel_q;
        din_d      = din_q;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        status_d   = status_q;
        regs_d     = regs_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    rsel_a_d   = rsel_a;
                    rsel_b_d   = rsel_b;
                    writenum_d = writenum;
                    shift_d    = shift;
                    aluop_d    = ALUop;
                    asel_d     = asel;
                    bsel_d     = bsel;
                    vsel_d     = vsel;
                    din_d      = datapath_in;
                    state_d    = vsel ? WB : RDA;
                end
            end
            RDA: begin
                a_d     = regs_q[rsel_a_q];
                state_d = RDB;
            end
            RDB: begin
                b_d     = regs_q[rsel_b_q];
                state_d = EXEC;
            end
            EXEC: begin
                c_d      = alu_res;
                status_d = {alu_v, alu_res[WIDTH-1], (alu_res == '0)};
                state_d  = WB;
            end
            WB: begin
                regs_d[writenum_q] = vsel_q ? din_q : c_q;
                state_d            = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the register file sits in the reset branch too, since an operation after reset must read zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rsel_a_q   <= '0;
            rsel_b_q   <= '0;
            writenum_q <= '0;
            shift_q    <= '0;
            aluop_q    <= '0;
            asel_q     <= 1'b0;
            bsel_q     <= 1'b0;
            vsel_q     <= 1'b0;
            din_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            status_q   <= '0;
            regs_q     <= '{default: '0};
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values of the others.
            state_q    <= state_d;
            rsel_a_q   <= rsel_a_d;
            rsel_b_q   <= rsel_b_d;
            writenum_q <= writenum_d;
            shift_q    <= shift_d;
            aluop_q    <= aluop_d;
            asel_q     <= asel_d;
            bsel_q     <= bsel_d;
            vsel_q     <= vsel_d;
            din_q      <= din_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            status_q   <= status_d;
            regs_q     <= regs_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign done         = (state_q == WB);
    assign status       = status_q;
    assign datapath_out = c_q;

endmodule

// File: tb/tb_datapath_seq.sv
// Randomized self-checking bench for datapath_seq: a 16-bit/8-register instance checked
// against an arithmetic model, plus a 32-bit/16-register instance for reset and overflow.
module tb_datapath_seq;

    localparam int W   = 16;
    localparam int NR  = 8;
    localparam int IW  = 3;
    localparam int WW  = 32;
    localparam int NRW = 16;
    localparam int IWW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, start, asel, bsel, vsel;
    logic [IW-1:0] rsel_a, rsel_b, writenum;
    logic [1:0]    shift, alu_op;
    logic [W-1:0]  datapath_in, datapath_out;
    logic          busy, done;
    logic [2:0]    status;

    logic           rst_n_w, start_w, asel_w, bsel_w, vsel_w;
    logic [IWW-1:0] rsel_a_w, rsel_b_w, writenum_w;
    logic [1:0]     shift_w, alu_op_w;
    logic [WW-1:0]  datapath_in_w, datapath_out_w;
    logic           busy_w, done_w;
    logic [2:0]     status_w;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] mregs [NR];
    logic [W-1:0] m_c;
    logic [2:0]   m_status;

    datapath_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rsel_a(rsel_a), .rsel_b(rsel_b), .writenum(writenum),
        .shift(shift), .ALUop(alu_op), .asel(asel), .bsel(bsel), .vsel(vsel),
        .datapath_in(datapath_in), .busy(busy), .done(done),
        .status(status), .datapath_out(datapath_out)
    );

    datapath_seq #(.WIDTH(WW), .NREGS(NRW)) dut_w (
        .clk(clk), .rst_n(rst_n_w), .start(start_w),
        .rsel_a(rsel_a_w), .rsel_b(rsel_b_w), .writenum(writenum_w),
        .shift(shift_w), .ALUop(alu_op_w), .asel(asel_w), .bsel(bsel_w), .vsel(vsel_w),
        .datapath_in(datapath_in_w), .busy(busy_w), .done(done_w),
        .status(status_w), .datapath_out(datapath_out_w)
    );

    initial begin
        #500000;
        $display("FAIL watchdog expired before the summary line");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        foreach (mregs[i]) mregs[i] = '0;
        m_c      = '0;
        m_status = '0;
    endtask

    // Operation semantics computed on signed/unsigned integers rather than bit vectors.
    task automatic model_apply(input logic v_i, input logic [IW-1:0] ra_i, rb_i, wn_i,
                               input logic [1:0] sh_i, op_i, input logic as_i, bs_i,
                               input logic [W-1:0] din_i);
        int a, b, bsh, bin, sa, sb, full, r;
        bit ovf;
        if (v_i) begin
            mregs[wn_i] = din_i;
            return;
        end
        a = as_i ? 0 : int'(mregs[ra_i]);
        b = int'(mregs[rb_i]);
        case (sh_i)
            2'd0:    bsh = b;
            2'd1:    bsh = (b * 2) % 65536;
            2'd2:    bsh = b / 2;
            default: bsh = b / 2 + ((b >= 32768) ? 32768 : 0);
        endcase
        bin = bs_i ? int'(din_i[4:0]) : bsh;
        sa  = (a >= 32768) ? a - 65536 : a;
        sb  = (bin >= 32768) ? bin - 65536 : bin;
        ovf = 1'b0;
        case (op_i)
            2'd0: begin
                full = sa + sb;
                r    = (a + bin) % 65536;
                ovf  = (full > 32767) || (full < -32768);
            end
            2'd1: begin
                full = sa - sb;
                r    = (a - bin + 65536) % 65536;
                ovf  = (full > 32767) || (full < -32768);
            end
            2'd2:    r = a & bin;
            default: r = 65535 - bin;
        endcase
        m_c         = r[W-1:0];
        m_status    = {ovf, (r >= 32768), (r == 0)};
        mregs[wn_i] = m_c;
    endtask

    task automatic scramble_inputs();
        rsel_a      = IW'($urandom());
        rsel_b      = IW'($urandom());
        writenum    = IW'($urandom());
        shift       = 2'($urandom());
        alu_op      = 2'($urandom());
        asel        = 1'($urandom());
        bsel        = 1'($urandom());
        vsel        = 1'($urandom());
        datapath_in = W'($urandom());
    endtask

    // NOTE: stimulus changes on the falling edge so the DUT never samples an input mid-update.
    task automatic do_op(input logic v_i, input logic [IW-1:0] ra_i, rb_i, wn_i,
                         input logic [1:0] sh_i, op_i, input logic as_i, bs_i,
                         input logic [W-1:0] din_i, input bit hold_i);
        int lat;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_before_op busy=%b expected 0", busy);
        end
        start = 1'b1; vsel = v_i; rsel_a = ra_i; rsel_b = rb_i; writenum = wn_i;
        shift = sh_i; alu_op = op_i; asel = as_i; bsel = bs_i; datapath_in = din_i;
        model_apply(v_i, ra_i, rb_i, wn_i, sh_i, op_i, as_i, bs_i, din_i);
        lat = v_i ? 1 : 4;
        @(posedge clk);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_cycle%0d busy=%b expected 1", k, busy);
            end
            checks++;
            if (done !== ((k == lat) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL done_cycle%0d done=%b expected %b", k, done, (k == lat));
            end
            if (!hold_i) start = 1'b0;
            scramble_inputs();
        end
        checks++;
        if (datapath_out !== m_c) begin
            errors++;
            $display("FAIL result datapath_out=%h expected %h", datapath_out, m_c);
        end
        checks++;
        if (status !== m_status) begin
            errors++;
            $display("FAIL status status=%b expected %b", status, m_status);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_op busy=%b done=%b expected 0 0", busy, done);
        end
        start = 1'b0;
    endtask

    task automatic load(input logic [IW-1:0] r, input logic [W-1:0] val);
        do_op(1'b1, '0, '0, r, 2'b00, 2'b00, 1'b0, 1'b0, val, 1'b0);
    endtask

    // Copies reg[r] through the ALU (0 + B) into C and back into itself.
    task automatic peek(input logic [IW-1:0] r);
        do_op(1'b0, '0, r, r, 2'b00, 2'b00, 1'b1, 1'b0, '0, 1'b0);
    endtask

    task automatic expect_out(input string name, input logic [W-1:0] exp_c, input logic [2:0] exp_s);
        checks++;
        if (datapath_out !== exp_c) begin
            errors++;
            $display("FAIL %s datapath_out=%h expected %h", name, datapath_out, exp_c);
        end
        checks++;
        if (status !== exp_s) begin
            errors++;
            $display("FAIL %s status=%b expected %b", name, status, exp_s);
        end
    endtask

    task automatic wide_cmd(input logic v_i, input logic [IWW-1:0] ra_i, rb_i, wn_i,
                            input logic [1:0] op_i, input logic as_i, input logic [WW-1:0] din_i);
        int cyc;
        @(negedge clk);
        start_w = 1'b1; vsel_w = v_i; rsel_a_w = ra_i; rsel_b_w = rb_i; writenum_w = wn_i;
        alu_op_w = op_i; asel_w = as_i; bsel_w = 1'b0; shift_w = 2'b00; datapath_in_w = din_i;
        @(posedge clk);
        @(negedge clk);
        start_w = 1'b0;
        cyc = 1;
        while (done_w !== 1'b1 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != (v_i ? 1 : 4)) begin
            errors++;
            $display("FAIL wide_latency cycles=%0d expected %0d", cyc, (v_i ? 1 : 4));
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst_n_w = 1'b0;
        scramble_inputs();
        start = 1'b1;
        start_w = 1'b1; vsel_w = 1'b0; rsel_a_w = '0; rsel_b_w = '0; writenum_w = '0;
        shift_w = '0; alu_op_w = '0; asel_w = 1'b0; bsel_w = 1'b0; datapath_in_w = '0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, status, datapath_out} !== '0) begin
            errors++;
            $display("FAIL reset_outputs busy=%b done=%b status=%b out=%h expected all 0",
                     busy, done, status, datapath_out);
        end
        checks++;
        if ({busy_w, done_w, status_w, datapath_out_w} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_wide busy=%b done=%b status=%b out=%h expected all 0",
                     busy_w, done_w, status_w, datapath_out_w);
        end
        rst_n = 1'b1; rst_n_w = 1'b1;
        start = 1'b0; start_w = 1'b0;
    endtask

    task automatic test_load();
        peek(3'd0);
        expect_out("peek_zero", 16'h0000, 3'b001);
        load(3'd3, 16'h0007);
        expect_out("load_keeps_c_status", 16'h0000, 3'b001);
        peek(3'd3);
        expect_out("load_reg3", 16'h0007, 3'b000);
    endtask

    task automatic test_add_shift();
        load(3'd0, 16'h0007);
        load(3'd1, 16'h0002);
        do_op(1'b0, 3'd0, 3'd1, 3'd4, 2'b01, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0);
        expect_out("add_shift", 16'h000B, 3'b000);
    endtask

    task automatic test_overflow();
        load(3'd0, 16'h7FFF);
        load(3'd1, 16'h0001);
        do_op(1'b0, 3'd0, 3'd1, 3'd5, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0);
        expect_out("overflow", 16'h8000, 3'b110);
    endtask

    task automatic test_zero();
        load(3'd0, 16'h0005);
        load(3'd1, 16'h0005);
        do_op(1'b0, 3'd0, 3'd1, 3'd6, 2'b00, 2'b01, 1'b0, 1'b0, 16'h0000, 1'b0);
        expect_out("sub_zero", 16'h0000, 3'b001);
        load(3'd2, 16'hFFFF);
        peek(3'd2);
        expect_out("peek_ffff", 16'hFFFF, 3'b010);
        do_op(1'b0, 3'd0, 3'd2, 3'd7, 2'b00, 2'b11, 1'b1, 1'b0, 16'h0000, 1'b0);
        expect_out("not_zero", 16'h0000, 3'b001);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            do_op(($urandom_range(3) == 0), IW'($urandom()), IW'($urandom()), IW'($urandom()),
                  2'($urandom()), 2'($urandom()), ($urandom_range(4) == 0), 1'($urandom()),
                  W'($urandom()), 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            do_op(($urandom_range(2) == 0), IW'($urandom()), IW'($urandom()), IW'($urandom()),
                  2'($urandom()), 2'($urandom()), 1'b0, 1'($urandom()),
                  W'($urandom()), 1'b1);
        end
    endtask

    task automatic test_mid_reset();
        load(3'd6, 16'h1234);
        @(negedge clk);
        start = 1'b1; vsel = 1'b0; rsel_a = 3'd6; rsel_b = 3'd6; writenum = 3'd2;
        shift = 2'b00; alu_op = 2'b00; asel = 1'b0; bsel = 1'b0; datapath_in = '0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL exec_busy busy=%b expected 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, status, datapath_out} !== '0) begin
            errors++;
            $display("FAIL abort_outputs busy=%b done=%b status=%b out=%h expected all 0",
                     busy, done, status, datapath_out);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        peek(3'd2);
        expect_out("abort_dest", 16'h0000, 3'b001);
        peek(3'd6);
        load(3'd1, 16'h0003);
        do_op(1'b0, 3'd1, 3'd1, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0);
        expect_out("after_abort_add", 16'h0006, 3'b000);
    endtask

    task automatic test_wide();
        logic [WW-1:0] big;
        big = 32'h7FFF_FFFF;
        wide_cmd(1'b1, '0, '0, 4'd5, 2'b00, 1'b0, 32'hDEAD_BEEF);
        @(negedge clk);
        start_w = 1'b1; vsel_w = 1'b0; rsel_a_w = 4'd5; rsel_b_w = 4'd5; writenum_w = 4'd9;
        alu_op_w = 2'b00; asel_w = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start_w = 1'b0;
        repeat (2) @(negedge clk);
        rst_n_w = 1'b0;
        #1;
        checks++;
        if ({busy_w, done_w, status_w, datapath_out_w} !== '0) begin
            errors++;
            $display("FAIL wide_abort busy=%b done=%b status=%b out=%h expected all 0",
                     busy_w, done_w, status_w, datapath_out_w);
        end
        @(negedge clk);
        rst_n_w = 1'b1;
        wide_cmd(1'b0, '0, 4'd9, 4'd9, 2'b00, 1'b1, '0);
        checks++;
        if (datapath_out_w !== '0 || status_w !== 3'b001) begin
            errors++;
            $display("FAIL wide_abort_dest out=%h status=%b expected 0 001", datapath_out_w, status_w);
        end
        wide_cmd(1'b0, '0, 4'd5, 4'd5, 2'b00, 1'b1, '0);
        checks++;
        if (datapath_out_w !== '0) begin
            errors++;
            $display("FAIL wide_reg_cleared out=%h expected 0", datapath_out_w);
        end
        wide_cmd(1'b1, '0, '0, 4'd1, 2'b00, 1'b0, big);
        wide_cmd(1'b1, '0, '0, 4'd2, 2'b00, 1'b0, 32'h0000_0001);
        wide_cmd(1'b0, 4'd1, 4'd2, 4'd3, 2'b00, 1'b0, '0);
        checks++;
        if (datapath_out_w !== big + 32'd1 || status_w !== 3'b110) begin
            errors++;
            $display("FAIL wide_overflow out=%h status=%b expected %h 110",
                     datapath_out_w, status_w, big + 32'd1);
        end
        wide_cmd(1'b0, 4'd1, 4'd2, 4'd4, 2'b01, 1'b0, '0);
        checks++;
        if (datapath_out_w !== big - 32'd1 || status_w !== 3'b000) begin
            errors++;
            $display("FAIL wide_sub out=%h status=%b expected %h 000",
                     datapath_out_w, status_w, big - 32'd1);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_add_shift();
        test_overflow();
        test_zero();
        test_random();
        test_back_to_back();
        test_mid_reset();
        test_wide();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
